ac_register_bank: RTL
=====================

// Module: ac_register_bank
// PURPOSE
//  Parametrised successor to the single accumulator register: a bank of NUM_AC
//  WIDTH-bit accumulators for the matrix-multiply datapath.
//  Each entry supports load from the data bus, load from the ALU, increment,
//  clear and in-place accumulate (ac += alu_out) for dot-product partial sums.
//  Each entry also keeps a saturating accumulate counter and a sticky overflow flag.
//  Sits between the ALU and the data bus; one write port, one read port.
// PARAMETERS
//  WIDTH   24  accumulator/data width in bits
//  NUM_AC  4   number of accumulators (1..2**SEL_W)
//  SEL_W   2   width of select ports
//  CNT_W   8   width of per-entry accumulate counter
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  sel        in   SEL_W  target accumulator for this cycle's operation
//  clr        in   1      clear target
//  write_en   in   1      load data_in into target
//  alu_to_ac  in   1      load alu_out into target
//  acc_en     in   1      target <= target + alu_out
//  incre      in   1      target <= target + 1
//  data_in    in   WIDTH  data bus input
//  alu_out    in   WIDTH  ALU result input
//  rd_sel     in   SEL_W  read select
//  data_out   out  WIDTH  ac[rd_sel]
//  acc_count  out  CNT_W  accumulate count of ac[rd_sel]
//  zero       out  1      ac[rd_sel] == 0
//  ovf        out  1      sticky overflow flag of ac[rd_sel]
// BEHAVIOUR
//  - Reset (rst low, asynchronous):
//    - all ac, counts and ovf flags go to 0 immediately;
//    - therefore data_out=0, acc_count=0, zero=1, ovf=0.
//    - Reset mid-operation discards the in-flight write.
//  - Write priority, one op per cycle on ac[sel]:
//    clr > write_en > alu_to_ac > acc_en > incre. Lower-priority requests that
//    cycle are dropped, not queued. No request asserted: the entry holds.
//  - Latency: the op takes effect at the rising edge; visible on the read port
//    the same cycle after the edge.
//  - Read port is combinational from the registers: no read latency;
//    read-during-write returns the old value until the edge.
//  - Arithmetic:
//    - unsigned, modulo 2**WIDTH;
//    - wrap on acc_en (carry-out) or incre (all-ones +1) sets the target's ovf;
//    - ovf stays set until clr, write_en or alu_to_ac on that entry.
//  - acc_count:
//    - +1 on each executed acc_en;
//    - saturates at 2**CNT_W-1 (no wrap);
//    - cleared by clr, write_en or alu_to_ac;
//    - unchanged by incre.
//  - Out-of-range indices (>= NUM_AC):
//    - sel out of range: the write is ignored, no state changes;
//    - rd_sel out of range: outputs read 0, zero=1, ovf=0.
//  - Entries other than ac[sel] never change in a given cycle.
// TESTING
//  1. rst low mid-cycle while ac0=20 -> all outputs 0/zero=1 without clock edge; hold after release.
//  2. sel=1, write_en, data_in=20; next cycle alu_to_ac, alu_out=64 -> rd_sel=1 reads 20 then 64; ac0 stays 0.
//  3. sel=2, acc_en x3 with alu_out=5,7,9 -> data_out 21, acc_count 3; then incre -> 22, count 3.
//  4. ac3=24'hFFFFFF, incre -> data_out 0, zero=1, ovf=1; then write_en data_in=43 -> 43, ovf=0, count 0.
//  5. clr+write_en+acc_en same cycle on ac1=43 -> ac1=0; write_en+acc_en only -> data_in wins, count 0.
//  6. CNT_W=2, 5 acc_en ops -> acc_count 3 (saturated); NUM_AC=3, sel=3 write -> no entry changes.

Source files
------------

// File: rtl/ac_register_bank.sv
// ac_register_bank: bank of accumulators with per-entry accumulate counter and sticky overflow
module ac_register_bank #(
    parameter int WIDTH  = 24,
    parameter int NUM_AC = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] sel,
    input  logic             clr,
    input  logic             write_en,
    input  logic             alu_to_ac,
    input  logic             acc_en,
    input  logic             incre,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [WIDTH-1:0] data_out,
    output logic [CNT_W-1:0] acc_count,
    output logic             zero,
    output logic             ovf
);
    logic [WIDTH-1:0] ac_v  [NUM_AC];
    logic [CNT_W-1:0] cnt_v [NUM_AC];
    logic             ovf_v [NUM_AC];

    for (genvar i = 0; i < NUM_AC; i++) begin : g_ac
        logic [WIDTH-1:0] q;
        logic [CNT_W-1:0] cnt;
        logic             of;
        logic             hit;
        logic [WIDTH:0]   sum;
        assign hit = sel == SEL_W'(i);
        assign sum = {1'b0, q} + {1'b0, alu_out};
        assign ac_v[i]  = q;
        assign cnt_v[i] = cnt;
        assign ovf_v[i] = of;
        // Apply the highest-priority requested op to this entry when it is selected
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                q   <= '0;
                cnt <= '0;
                of  <= 1'b0;
            end else if (hit) begin
                if (clr) begin
                    q   <= '0;
                    cnt <= '0;
                    of  <= 1'b0;
                end else if (write_en) begin
                    q   <= data_in;
                    cnt <= '0;
                    of  <= 1'b0;
                end else if (alu_to_ac) begin
                    q   <= alu_out;
                    cnt <= '0;
                    of  <= 1'b0;
                end else if (acc_en) begin
                    q   <= sum[WIDTH-1:0];
                    cnt <= (cnt == '1) ? cnt : cnt + CNT_W'(1);
                    of  <= of | sum[WIDTH];
                end else if (incre) begin
                    q   <= q + WIDTH'(1);
                    of  <= of | (&q);
                end
            end
        end
    end

    // Combinational read port; out-of-range rd_sel reads as an empty entry
    always_comb begin
        data_out  = '0;
        acc_count = '0;
        ovf       = 1'b0;
        for (int i = 0; i < NUM_AC; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                data_out  = ac_v[i];
                acc_count = cnt_v[i];
                ovf       = ovf_v[i];
            end
        end
        zero = data_out == '0;
    end
endmodule
